packet_scheduler: RTL and testbench

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/packet_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_packet_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/packet_scheduler.sv
// HDMI data-island packet scheduler: places guard bands and 32-cycle packet slots after active video.
// Optional build macro HDMI_SPD_INFOFRAME_EN enables SPD InfoFrame scheduling.
module packet_scheduler #(
    parameter int unsigned SCREEN_WIDTH = 640,
    parameter int unsigned FRAME_WIDTH  = 800,
    parameter int unsigned NUM_PACKETS  = 1,
    parameter int unsigned BIT_WIDTH    = 10
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    input  logic [BIT_WIDTH-1:0] cx,
    input  logic [BIT_WIDTH-1:0] cy,
    input  logic                 acr_req,
    input  logic                 sample_strobe,
    output logic [7:0]           packet_type,
    output logic [3:0]           sample_present,
    output logic                 packet_start,
    output logic [4:0]           data_counter,
    output logic                 data_island_period,
    output logic                 guard_band,
    output logic                 sample_overflow
);

    localparam int unsigned GB1_START    = SCREEN_WIDTH + 8;
    localparam int unsigned ISLAND_START = SCREEN_WIDTH + 10;
    localparam int unsigned ISLAND_END   = ISLAND_START + NUM_PACKETS * 32;
    localparam int unsigned GB2_END      = ISLAND_END + 2;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned CNT_MAX      = (1 << CNT_W) - 1;

    if (GB2_END > FRAME_WIDTH) begin : g_bad_frame
        $error("packet_scheduler: data island does not fit in FRAME_WIDTH");
    end
    if (NUM_PACKETS < 1 || NUM_PACKETS > 18) begin : g_bad_packets
        $error("packet_scheduler: NUM_PACKETS out of range 1..18");
    end

    logic [7:0]       packet_type_q, packet_type_d;
    logic [3:0]       sample_present_q, sample_present_d;
    logic             packet_start_q, packet_start_d;
    logic [4:0]       data_counter_q, data_counter_d;
    logic             island_q, island_d;
    logic             guard_q, guard_d;
    logic             overflow_q, overflow_d;
    logic             armed_q, armed_d;
    logic             acr_q, acr_d;
    logic             avi_q, avi_d;
    logic             aif_q, aif_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef HDMI_SPD_INFOFRAME_EN
    logic             spd_q, spd_d;
    logic             grant_spd;
`endif

    logic [31:0]      cx_w;
    logic             frame_start;
    logic             in_island;
    logic [4:0]       slot_idx;
    logic             slot_start;
    logic             grant_acr, grant_avi, grant_aif;
    logic [2:0]       taken;
    logic [CNT_W:0]   cnt_sum;

    // Timing decode, slot arbitration and pending-state update.
    always_comb begin
        cx_w        = 32'(cx);
        frame_start = (cx_w == 32'd0) && (cy == '0);
        // After reset, stay idle until the first guard band so partial slots never resume.
        armed_d     = armed_q | (cx_w == GB1_START);
        guard_d     = armed_d && (((cx_w >= GB1_START) && (cx_w < ISLAND_START)) ||
                                  ((cx_w >= ISLAND_END) && (cx_w < GB2_END)));
        in_island   = armed_d && (cx_w >= ISLAND_START) && (cx_w < ISLAND_END);
        slot_idx    = 5'(cx_w - ISLAND_START);
        slot_start  = in_island && (slot_idx == 5'd0);

        grant_acr        = 1'b0;
        grant_avi        = 1'b0;
        grant_aif        = 1'b0;
`ifdef HDMI_SPD_INFOFRAME_EN
        grant_spd        = 1'b0;
`endif
        taken            = 3'd0;
        packet_type_d    = packet_type_q;
        sample_present_d = sample_present_q;

        if (!in_island) begin
            packet_type_d    = 8'h00;
            sample_present_d = 4'h0;
        end else if (slot_start) begin
            sample_present_d = 4'h0;
            if (acr_q) begin
                grant_acr     = 1'b1;
                packet_type_d = 8'h01;
            end else if (cnt_q != '0) begin
                taken            = (cnt_q > 4'd4) ? 3'd4 : 3'(cnt_q);
                packet_type_d    = 8'h02;
                sample_present_d = 4'((5'b1 << taken) - 5'd1);
            end else if (avi_q) begin
                grant_avi     = 1'b1;
                packet_type_d = 8'h82;
            end else if (aif_q) begin
                grant_aif     = 1'b1;
                packet_type_d = 8'h84;
`ifdef HDMI_SPD_INFOFRAME_EN
            end else if (spd_q) begin
                grant_spd     = 1'b1;
                packet_type_d = 8'h83;
`endif
            end else begin
                packet_type_d = 8'h00;
            end
        end

        island_d       = in_island;
        packet_start_d = slot_start;
        data_counter_d = in_island ? slot_idx : 5'd0;

        acr_d = (acr_q & ~grant_acr) | acr_req;
        avi_d = frame_start | (avi_q & ~grant_avi);
        aif_d = frame_start | (aif_q & ~grant_aif);
`ifdef HDMI_SPD_INFOFRAME_EN
        spd_d = frame_start | (spd_q & ~grant_spd);
`endif

        // Pending-sample counter saturates at its maximum and latches the overflow flag.
        cnt_sum    = (CNT_W+1)'(cnt_q) - (CNT_W+1)'(taken) + (CNT_W+1)'(sample_strobe);
        overflow_d = overflow_q;
        if (cnt_sum > (CNT_W+1)'(CNT_MAX)) begin
            cnt_d      = CNT_W'(CNT_MAX);
            overflow_d = 1'b1;
        end else begin
            cnt_d = CNT_W'(cnt_sum);
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            packet_type_q    <= 8'h00;
            sample_present_q <= 4'h0;
            packet_start_q   <= 1'b0;
            data_counter_q   <= 5'd0;
            island_q         <= 1'b0;
            guard_q          <= 1'b0;
            overflow_q       <= 1'b0;
            armed_q          <= 1'b0;
            acr_q            <= 1'b0;
            avi_q            <= 1'b0;
            aif_q            <= 1'b0;
            cnt_q            <= '0;
        end else begin
            packet_type_q    <= packet_type_d;
            sample_present_q <= sample_present_d;
            packet_start_q   <= packet_start_d;
            data_counter_q   <= data_counter_d;
            island_q         <= island_d;
            guard_q          <= guard_d;
            overflow_q       <= overflow_d;
            armed_q          <= armed_d;
            acr_q            <= acr_d;
            avi_q            <= avi_d;
            aif_q            <= aif_d;
            cnt_q            <= cnt_d;
        end
    end

`ifdef HDMI_SPD_INFOFRAME_EN
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            spd_q <= 1'b0;
        end else begin
            spd_q <= spd_d;
        end
    end
`endif

    assign packet_type        = packet_type_q;
    assign sample_present     = sample_present_q;
    assign packet_start       = packet_start_q;
    assign data_counter       = data_counter_q;
    assign data_island_period = island_q;
    assign guard_band         = guard_q;
    assign sample_overflow    = overflow_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler at default parameters; honours HDMI_SPD_INFOFRAME_EN.
module tb_packet_scheduler;

    logic       clk_pixel = 1'b0;
    logic       reset_n;
    logic [9:0] cx;
    logic [9:0] cy;
    logic       acr_req;
    logic       sample_strobe;
    logic [7:0] packet_type;
    logic [3:0] sample_present;
    logic       packet_start;
    logic [4:0] data_counter;
    logic       data_island_period;
    logic       guard_band;
    logic       sample_overflow;

    packet_scheduler dut (
        .clk_pixel          (clk_pixel),
        .reset_n            (reset_n),
        .cx                 (cx),
        .cy                 (cy),
        .acr_req            (acr_req),
        .sample_strobe      (sample_strobe),
        .packet_type        (packet_type),
        .sample_present     (sample_present),
        .packet_start       (packet_start),
        .data_counter       (data_counter),
        .data_island_period (data_island_period),
        .guard_band         (guard_band),
        .sample_overflow    (sample_overflow)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        int         cx;
        logic       gb;
        logic       dip;
        logic       ps;
        logic [4:0] dc;
        logic [7:0] pt;
        logic [3:0] sp;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

`ifdef HDMI_SPD_INFOFRAME_EN
    localparam logic [7:0] THIRD_SLOT = 8'h83;
`else
    localparam logic [7:0] THIRD_SLOT = 8'h00;
`endif

    // Monitor: every guard/island output cycle must match the next queued expectation.
    always @(negedge clk_pixel) begin
        if (reset_n && (guard_band || data_island_period)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output gb=%0b dip=%0b pt=%h (no expectation queued)",
                         guard_band, data_island_period, packet_type);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (guard_band !== e.gb || data_island_period !== e.dip || packet_start !== e.ps ||
                    data_counter !== e.dc || packet_type !== e.pt || sample_present !== e.sp) begin
                    fails++;
                    $display("FAIL slot_cx%0d actual gb=%0b dip=%0b ps=%0b dc=%0d pt=%h sp=%b required gb=%0b dip=%0b ps=%0b dc=%0d pt=%h sp=%b",
                             e.cx, guard_band, data_island_period, packet_start, data_counter,
                             packet_type, sample_present, e.gb, e.dip, e.ps, e.dc, e.pt, e.sp);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int c, input logic [7:0] t, input logic [3:0] sp);
        exp_t e;
        e.cx  = c;
        e.gb  = ((c >= 648) && (c < 650)) || ((c >= 682) && (c < 684));
        e.dip = (c >= 650) && (c < 682);
        e.dc  = e.dip ? 5'(c - 650) : 5'd0;
        e.ps  = e.dip && (e.dc == 5'd0);
        e.pt  = e.dip ? t : 8'h00;
        e.sp  = e.dip ? sp : 4'h0;
        if (e.gb || e.dip) exp_q.push_back(e);
    endtask

    task automatic drive(input int c, input int y, input logic a, input logic s);
        cx            = 10'(c);
        cy            = 10'(y);
        acr_req       = a;
        sample_strobe = s;
        @(posedge clk_pixel);
        #1;
    endtask

    // One full line; acr pulses at acr_a/acr_b (-1 = none), n_str strobes from cx 10.
    task automatic run_line(input int y, input int acr_a, input int acr_b, input int n_str,
                            input logic [7:0] t, input logic [3:0] sp);
        for (int c = 0; c < 800; c++) begin
            push_exp(c, t, sp);
            drive(c, y, (c == acr_a) || (c == acr_b), (c >= 10) && (c < 10 + n_str));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pt"},  int'(packet_type), 0);
        chk({tag, "_sp"},  int'(sample_present), 0);
        chk({tag, "_ps"},  int'(packet_start), 0);
        chk({tag, "_dc"},  int'(data_counter), 0);
        chk({tag, "_dip"}, int'(data_island_period), 0);
        chk({tag, "_gb"},  int'(guard_band), 0);
        chk({tag, "_ovf"}, int'(sample_overflow), 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        cx            = '0;
        cy            = 10'd1;
        acr_req       = 1'b0;
        sample_strobe = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Idle line: guard/island timing with a null slot.
        run_line(1, -1, -1, 0, 8'h00, 4'h0);

        // ACR requested together with the third sample: ACR wins, audio follows, then empty.
        run_line(1, 12, -1, 3, 8'h01, 4'h0);
        run_line(1, -1, -1, 0, 8'h02, 4'b0111);
        run_line(1, -1, -1, 0, 8'h00, 4'h0);

        // Request landing in the ACR grant cycle is retained for the next slot.
        run_line(1, 10, 650, 0, 8'h01, 4'h0);
        run_line(1, -1, -1, 0, 8'h01, 4'h0);
        run_line(1, -1, -1, 0, 8'h00, 4'h0);

        // Frame start: AVI, audio InfoFrame, then SPD (or null), then null.
        run_line(0, -1, -1, 0, 8'h82, 4'h0);
        run_line(1, -1, -1, 0, 8'h84, 4'h0);
        run_line(1, -1, -1, 0, THIRD_SLOT, 4'h0);
        run_line(1, -1, -1, 0, 8'h00, 4'h0);

        // 20 strobes outside any island: counter saturates, overflow latches.
        chk("overflow_before", int'(sample_overflow), 0);
        for (int i = 0; i < 20; i++) drive(100, 1, 1'b0, 1'b1);
        drive(101, 1, 1'b0, 1'b0);
        chk("overflow_set", int'(sample_overflow), 1);
        run_line(1, -1, -1, 0, 8'h02, 4'b1111);
        chk("overflow_sticky", int'(sample_overflow), 1);

        // Reset mid-slot: outputs clear at once, island stays dark until next line.
        for (int c = 0; c < 660; c++) begin
            push_exp(c, 8'h02, 4'b1111);
            drive(c, 1, 1'b0, 1'b0);
        end
        @(negedge clk_pixel);
        #1;
        chk("pre_reset_dip", int'(data_island_period), 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midslot_reset");
        drive(660, 1, 1'b0, 1'b0);
        drive(661, 1, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int c = 662; c < 800; c++) drive(c, 1, 1'b0, 1'b0);
        // Counter was cleared by reset, so the next slot is null.
        run_line(1, -1, -1, 0, 8'h00, 4'h0);

        @(negedge clk_pixel);
        chk("leftover_expectations", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
